// File: rtl/read_response.sv
// ---------------------------------------------------------------------------
// read_response
//
// Purpose:
//   Consumes the internal read request (valid + 32-bit byte address) from the
//   AXI read-request stage and decodes it into a local bank of NUM_REGS 32-bit
//   registers. The word is returned on an AXI-style R channel with a
//   valid/ready handshake. A simple write port lets the write path fill the
//   bank. The FSM walks IDLE -> LOOKUP -> RESP -> IDLE. Requests arriving in
//   LOOKUP or RESP are not accepted; upstream keeps holding them.
//
// Optional feature (macro READ_TIMEOUT_EN):
//   When defined, a response that sits in RESP for TIMEOUT_CYCLES cycles
//   without a handshake is dropped. o_rvalid falls, the FSM returns to IDLE
//   and o_timeout pulses for one cycle. A handshake on the final cycle still
//   completes normally. When undefined, o_rvalid is held until the handshake
//   and o_timeout is constant 0.
//
// Ports:
//   clk                 clock, all logic on the rising edge
//   i_reset             synchronous reset, active-low
//   i_arvalid_internal  internal read request valid
//   i_araddr_internal   internal read byte address (32)
//   o_req_ready         high only in IDLE
//   i_wr_en             bank write strobe
//   i_wr_idx            bank index to write (IDX_W)
//   i_wr_data           bank write data (32)
//   i_rready            R-channel ready from the master
//   o_rvalid            R-channel valid
//   o_rdata             R-channel data (32)
//   o_rresp             2'b00 OKAY, 2'b10 SLVERR
//   o_timeout           one-cycle pulse when a response times out
// ---------------------------------------------------------------------------
module read_response #(
    parameter int NUM_REGS       = 16,
    parameter int IDX_W          = $clog2(NUM_REGS),
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_arvalid_internal,
    input  logic [31:0]      i_araddr_internal,
    output logic             o_req_ready,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [31:0]      i_wr_data,
    input  logic             i_rready,
    output logic             o_rvalid,
    output logic [31:0]      o_rdata,
    output logic [1:0]       o_rresp
    ,
    output logic             o_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOOKUP = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    // First byte address past the bank; compared against the full 32-bit
    // address so that upper address bits never alias back into the bank.
    localparam logic [31:0] ADDR_LIMIT = 32'(NUM_REGS * 4);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t            state_r;
    state_t            state_next_s;
    logic [31:0]       addr_r;
    logic              err_r;
    logic [31:0]       bank_r [NUM_REGS];
    logic              rvalid_r;
    logic [31:0]       rdata_r;
    logic [1:0]        rresp_r;
    logic              req_ready_r;
    logic              timeout_r;
    logic              handshake_s;
    logic              timeout_hit_s;

    // A request is an error when it is misaligned or falls outside the bank.
    function automatic logic addr_is_err(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr >= ADDR_LIMIT);
    endfunction

    assign handshake_s = rvalid_r & i_rready;

`ifdef READ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] resp_cnt_r;

    // The count holds the number of RESP cycles already spent with i_rready low.
    // It expires in the TIMEOUT_CYCLES-th such cycle unless that cycle handshakes.
    assign timeout_hit_s = (state_r == ST_RESP) && !i_rready &&
                           (resp_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Response age counter: cleared on the way into RESP, counts stalled cycles.
    always_ff @(posedge clk) begin
        if (!i_reset) begin
            resp_cnt_r <= '0;
        end else if (state_r == ST_LOOKUP) begin
            resp_cnt_r <= '0;
        end else if ((state_r == ST_RESP) && !i_rready) begin
            resp_cnt_r <= resp_cnt_r + CNT_W'(1);
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout_hit_s = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!i_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_arvalid_internal) begin
                    state_next_s = ST_LOOKUP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                state_next_s = ST_RESP;
            end
            ST_RESP: begin
                if (handshake_s || timeout_hit_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Request capture, decode result and registered R-channel outputs.
    always_ff @(posedge clk) begin
        if (!i_reset) begin
            addr_r      <= 32'h0000_0000;
            err_r       <= 1'b0;
            rdata_r     <= 32'h0000_0000;
            rresp_r     <= RESP_OKAY;
            rvalid_r    <= 1'b0;
            req_ready_r <= 1'b1;
            timeout_r   <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && i_arvalid_internal) begin
                addr_r <= i_araddr_internal;
                err_r  <= addr_is_err(i_araddr_internal);
            end
            // The bank is read before any same-edge write lands, so a write
            // to the index being looked up returns the old value.
            if (state_r == ST_LOOKUP) begin
                rdata_r <= err_r ? 32'h0000_0000 : bank_r[addr_r[IDX_W+1:2]];
                rresp_r <= err_r ? RESP_SLVERR : RESP_OKAY;
            end
            rvalid_r    <= (state_next_s == ST_RESP);
            req_ready_r <= (state_next_s == ST_IDLE);
            timeout_r   <= timeout_hit_s;
        end
    end

    // Register bank write port; active in every state outside reset.
    always_ff @(posedge clk) begin
        if (!i_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                bank_r[i] <= 32'h0000_0000;
            end
        end else if (i_wr_en) begin
            bank_r[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_req_ready = req_ready_r;
    assign o_rvalid    = rvalid_r;
    assign o_rdata     = rdata_r;
    assign o_rresp     = rresp_r;
    assign o_timeout   = timeout_r;

endmodule

// File: tb/tb_read_response.sv
// ---------------------------------------------------------------------------
// tb_read_response
//
// Self-checking bench for read_response. A transaction-level reference model
// (an array holding the bank contents plus the address decode rules) gives
// the expected response for every read. Directed scenarios come first,
// followed by randomized reads with random background writes.
// ---------------------------------------------------------------------------
module tb_read_response;

    localparam int NUM_REGS = 16;
    localparam int IDX_W    = $clog2(NUM_REGS);
    localparam int TO       = 8;

    logic             clk;
    logic             i_reset;
    logic             i_arvalid_internal;
    logic [31:0]      i_araddr_internal;
    logic             o_req_ready;
    logic             i_wr_en;
    logic [IDX_W-1:0] i_wr_idx;
    logic [31:0]      i_wr_data;
    logic             i_rready;
    logic             o_rvalid;
    logic [31:0]      o_rdata;
    logic [1:0]       o_rresp;
    logic             o_timeout;

    int          checks;
    int          errors;
    logic [31:0] model [NUM_REGS];
    bit          rand_wr_on;
    bit          hold_req;
    logic [31:0] hold_addr;

    read_response #(
        .NUM_REGS       (NUM_REGS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                (clk),
        .i_reset            (i_reset),
        .i_arvalid_internal (i_arvalid_internal),
        .i_araddr_internal  (i_araddr_internal),
        .o_req_ready        (o_req_ready),
        .i_wr_en            (i_wr_en),
        .i_wr_idx           (i_wr_idx),
        .i_wr_data          (i_wr_data),
        .i_rready           (i_rready),
        .o_rvalid           (o_rvalid),
        .o_rdata            (o_rdata),
        .o_rresp            (o_rresp),
        .o_timeout          (o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge: the model absorbs whatever the bench drove into the
    // edge, then the next cycle's background write is chosen.
    task automatic tick();
        @(posedge clk);
        if (!i_reset) begin
            for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0000_0000;
        end else if (i_wr_en) begin
            model[i_wr_idx] = i_wr_data;
        end
        #1;
        i_wr_en = 1'b0;
        if (rand_wr_on && ($urandom_range(0, 3) == 0)) begin
            i_wr_en   = 1'b1;
            i_wr_idx  = IDX_W'($urandom_range(0, NUM_REGS - 1));
            i_wr_data = $urandom;
        end
    endtask

    // Full read: accept, lookup, then 'stall' cycles of i_rready low before
    // the handshake. Optionally writes lk_data to lk_idx in the LOOKUP cycle.
    task automatic read_txn(input logic [31:0] addr, input int stall, input bit lk_wr,
                            input logic [IDX_W-1:0] lk_idx, input logic [31:0] lk_data);
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        bit          err;
        check_eq("idle_req_ready", o_req_ready, 32'd1);
        i_arvalid_internal = 1'b1;
        i_araddr_internal  = addr;
        i_rready           = 1'b0;
        tick();
        i_arvalid_internal = hold_req;
        i_araddr_internal  = hold_addr;
        check_eq("lookup_req_ready", o_req_ready, 32'd0);
        check_eq("lookup_rvalid", o_rvalid, 32'd0);
        err   = (addr % 4 != 0) || (addr >= 32'(NUM_REGS * 4));
        exp_d = err ? 32'h0 : model[int'(addr / 4)];
        exp_r = err ? 2'b10 : 2'b00;
        if (lk_wr) begin
            i_wr_en   = 1'b1;
            i_wr_idx  = lk_idx;
            i_wr_data = lk_data;
        end
        tick();
        for (int s = 0; s <= stall; s++) begin
            check_eq("resp_rvalid", o_rvalid, 32'd1);
            check_eq("resp_rdata", o_rdata, exp_d);
            check_eq("resp_rresp", o_rresp, exp_r);
            check_eq("resp_req_ready", o_req_ready, 32'd0);
            check_eq("resp_timeout", o_timeout, 32'd0);
            i_rready = (s == stall);
            tick();
`ifdef READ_TIMEOUT_EN
            if ((s == TO - 1) && (s != stall)) begin
                check_eq("to_rvalid", o_rvalid, 32'd0);
                check_eq("to_pulse", o_timeout, 32'd1);
                check_eq("to_req_ready", o_req_ready, 32'd1);
                tick();
                check_eq("to_pulse_end", o_timeout, 32'd0);
                check_eq("to_rvalid_low", o_rvalid, 32'd0);
                return;
            end
`endif
        end
        check_eq("done_rvalid", o_rvalid, 32'd0);
        check_eq("done_req_ready", o_req_ready, 32'd1);
        check_eq("done_timeout", o_timeout, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        checks = 0;
        errors = 0;
        rand_wr_on = 1'b0;
        hold_req = 1'b0;
        hold_addr = 32'h0;
        i_reset = 1'b0;
        i_arvalid_internal = 1'b0;
        i_araddr_internal = 32'h0;
        i_wr_en = 1'b0;
        i_wr_idx = '0;
        i_wr_data = 32'h0;
        i_rready = 1'b0;
        tick();
        tick();
        check_eq("rst_rvalid", o_rvalid, 32'd0);
        check_eq("rst_rdata", o_rdata, 32'h0);
        check_eq("rst_rresp", o_rresp, 32'd0);
        check_eq("rst_timeout", o_timeout, 32'd0);
        check_eq("rst_req_ready", o_req_ready, 32'd1);
        i_reset = 1'b1;
        tick();

        // bank[3] readback with immediate ready
        i_wr_en = 1'b1; i_wr_idx = IDX_W'(3); i_wr_data = 32'hDEAD_BEEF;
        tick();
        read_txn(32'h0000_000C, 0, 1'b0, '0, 32'h0);

        // decode errors: out of range, misaligned, high bits set
        read_txn(32'h0000_0040, 0, 1'b0, '0, 32'h0);
        read_txn(32'h0000_0006, 0, 1'b0, '0, 32'h0);
        read_txn(32'hFFFF_FFFC, 1, 1'b0, '0, 32'h0);
        read_txn(32'h0001_000C, 0, 1'b0, '0, 32'h0);
        read_txn(32'h0000_003C, 0, 1'b0, '0, 32'h0);

        // five stalled cycles; a second request held through RESP
        hold_req = 1'b1; hold_addr = 32'h0000_000C;
        read_txn(32'h0000_0000, 5, 1'b0, '0, 32'h0);
        hold_req = 1'b0;
        read_txn(32'h0000_000C, 0, 1'b0, '0, 32'h0);

        // write to the index under lookup returns the old value
        i_wr_en = 1'b1; i_wr_idx = IDX_W'(5); i_wr_data = 32'h1111_1111;
        tick();
        read_txn(32'h0000_0014, 0, 1'b1, IDX_W'(5), 32'h2222_2222);
        read_txn(32'h0000_0014, 0, 1'b0, '0, 32'h0);

        // handshake on the last allowed cycle, then a long stall
        read_txn(32'h0000_0014, TO - 1, 1'b0, '0, 32'h0);
        read_txn(32'h0000_000C, TO + 4, 1'b0, '0, 32'h0);
        check_eq("after_long_ready", o_req_ready, 32'd1);

        // randomized reads with background writes
        rand_wr_on = 1'b1;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                0: a = $urandom;
                1: a = 32'($urandom_range(0, NUM_REGS - 1) * 4 + $urandom_range(1, 3));
                2: a = 32'(NUM_REGS * 4) + 32'($urandom_range(0, 255) * 4);
                default: a = 32'($urandom_range(0, NUM_REGS - 1) * 4);
            endcase
            read_txn(a, $urandom_range(0, 3), 1'b0, '0, 32'h0);
            if ($urandom_range(0, 3) == 0) tick();
        end
        rand_wr_on = 1'b0;
        tick();

        // reset in the middle of RESP discards the response and clears the bank
        for (int i = 0; i < NUM_REGS; i++) begin
            i_wr_en = 1'b1; i_wr_idx = IDX_W'(i); i_wr_data = 32'hA5A5_0000 | 32'(i);
            tick();
        end
        i_arvalid_internal = 1'b1; i_araddr_internal = 32'h0000_0008; i_rready = 1'b0;
        tick();
        i_arvalid_internal = 1'b0;
        tick();
        check_eq("pre_rst_rvalid", o_rvalid, 32'd1);
        check_eq("pre_rst_rdata", o_rdata, 32'hA5A5_0002);
        i_reset = 1'b0;
        i_rready = 1'b1;
        tick();
        check_eq("midrst_rvalid", o_rvalid, 32'd0);
        check_eq("midrst_rdata", o_rdata, 32'h0);
        check_eq("midrst_rresp", o_rresp, 32'd0);
        i_reset = 1'b1;
        tick();
        check_eq("postrst_rvalid", o_rvalid, 32'd0);
        check_eq("postrst_req_ready", o_req_ready, 32'd1);
        i_rready = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            read_txn(32'(i * 4), 0, 1'b0, '0, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
